// File: rtl/counter_observer.sv
// counter_observer: watches an upstream free-running counter, flags any step
// that is not exactly +1, counts wrap-arounds (saturating) and captures
// triggered snapshots of the counter into a small FIFO drained via
// valid/ready.
//
// Optional build macro COUNTER_OBSERVER_TIMESTAMP_EN: adds a free-running
// 16-bit cycle counter; each snapshot then also carries the cycle stamp,
// presented on snap_ts alongside snap_data.
module counter_observer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int WRAP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              cnt_vld,
  input  logic              trig,
  output logic [WIDTH-1:0]  snap_data,
  output logic              snap_valid,
  input  logic              snap_ready,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              step_err,
  output logic              ovf,
  input  logic              err_clr
`ifdef COUNTER_OBSERVER_TIMESTAMP_EN
  ,
  output logic [15:0]       snap_ts
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef COUNTER_OBSERVER_TIMESTAMP_EN
  localparam int TS_W    = 16;
  localparam int ENTRY_W = WIDTH + TS_W;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  typedef enum logic {
    IDLE,
    TRACK
  } state_t;

  // Step-check FSM state
  state_t             state_q;
  logic [WIDTH-1:0]   prev_q;
  logic [WRAP_W-1:0]  wrap_count_q;
  logic               step_err_q;

  // Snapshot FIFO state
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic               snap_valid_q;
  logic               ovf_q;

  logic [ENTRY_W-1:0] entry_in;
  logic [WIDTH-1:0]   expect_nxt;
  logic               track_chk;
  logic               step_hit;
  logic               wrap_hit;
  logic               wrap_sat;
  logic               push_req;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic               drop;

`ifdef COUNTER_OBSERVER_TIMESTAMP_EN
  logic [TS_W-1:0]    ts_q;

  // Free-running cycle stamp, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end

  assign entry_in = {ts_q, cnt_in};
  assign snap_ts  = head_q[ENTRY_W-1:WIDTH];
`else
  assign entry_in = cnt_in;
`endif

  // Step and wrap detection against the previously observed value
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    expect_nxt = prev_q + WIDTH'(1);
    track_chk  = (state_q == TRACK) && cnt_vld;
    step_hit   = track_chk && (cnt_in != expect_nxt);
    wrap_hit   = track_chk && (prev_q == '1) && (cnt_in == '0);
    wrap_sat   = (wrap_count_q == '1);
  end

  // Resync FSM: IDLE loads prev without checking, TRACK checks and resyncs
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      wrap_count_q <= '0;
      step_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cnt_vld) begin
            prev_q  <= cnt_in;
            state_q <= TRACK;
          end
        end
        TRACK: begin
          if (!cnt_vld) state_q <= IDLE;
          else          prev_q  <= cnt_in;
        end
        default: state_q <= IDLE;
      endcase
      // A new error in the same cycle as err_clr wins over the clear.
      step_err_q <= step_hit | (step_err_q & ~err_clr);
      if (wrap_hit && !wrap_sat) wrap_count_q <= wrap_count_q + 1'b1;
    end
  end

  // FIFO next-state: occupancy, pointers and the value that will be at the head
  always_comb begin
    push_req = trig & cnt_vld;
    pop      = snap_valid_q & snap_ready;
    full     = (count_q == CNT_W'(DEPTH));
    // When full, a simultaneous pop frees the slot the push lands in.
    push_ok  = push_req & (~full | pop);
    drop     = push_req & full & ~pop;

    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // The next head is the entry being written this cycle when the read
    // pointer lands on the write slot (empty push, or pop+push with one entry).
    if (push_ok && (rd_ptr_d == wr_ptr_q)) head_d = entry_in;
    else                                   head_d = mem_q[rd_ptr_d];
  end

  // FIFO control, registered head and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      snap_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      snap_valid_q <= (count_d != '0);
      if (count_d != '0) head_q <= head_d;
      ovf_q        <= drop | (ovf_q & ~err_clr);
    end
  end

  // Snapshot storage
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; occupancy and pointers gate every read, so
    // stale contents are never observed and the array maps to plain RAM.
    if (push_ok) mem_q[wr_ptr_q] <= entry_in;
  end

  assign snap_data  = head_q[WIDTH-1:0];
  assign snap_valid = snap_valid_q;
  assign wrap_count = wrap_count_q;
  assign step_err   = step_err_q;
  assign ovf        = ovf_q;

endmodule
